servo_pwm_drive: RTL and testbench

- Downstream stage of one leg's inverse-kinematics pose pipeline; one instance per servo, six per platform.
- Consumes the arcsine argument (LUTin), the arctangent term (atan) and the valid strobe of that stage.
- Resolves servo angle alpha = asin(LUTin) - atan through a synchronous arcsine ROM and converts it to a saturated pulse width in microseconds.
- Drives a 50 Hz servo PWM output whose width updates only at frame boundaries, so no glitched pulses are produced.

---
 rtl/servo_pkg.sv | 63 ++++++
 rtl/servo_pwm_drive_asin_lut.sv | 37 +++
 rtl/servo_pwm_drive.sv | 193 +++++++++++++++++++
 tb/tb_servo_pwm_drive.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// ---------------------------------------------------------------------------
// servo_pkg
// Purpose : shared fixed-point widths, default timing constants and the
//           arcsine table generator used by every servo leg instance.
// Contents: ASIN_W/LUTIN_W/ADDR_W/ALPHA_W widths, product/offset widths,
//           default PWM timing, asin_entry() constant function.
// ---------------------------------------------------------------------------
package servo_pkg;

  localparam int ASIN_W    = 13;  // Q2.10 radians
  localparam int LUTIN_W   = 17;  // Q1.15 arcsine argument
  localparam int ADDR_W    = 10;
  localparam int ALPHA_W   = 14;  // asin - atan, cannot overflow
  localparam int PROD_W    = 25;  // alpha * gain
  localparam int OFF_W     = 16;  // signed pulse offset in us
  localparam int LUT_DEPTH = 1 << ADDR_W;

  localparam int DEF_CLK_DIV    = 100;
  localparam int DEF_PERIOD_US  = 20000;
  localparam int DEF_CENTER_US  = 1500;
  localparam int DEF_MIN_US     = 1000;
  localparam int DEF_MAX_US     = 2000;
  localparam int DEF_US_PER_RAD = 637;

  localparam real HALF_PI = 1.5707963267948966;

  // Taylor series sine; accurate far beyond table resolution on [0, pi/2].
  function automatic real sin_series(input real t);
    real term;
    real acc;
    term = t;
    acc  = t;
    for (int n = 1; n < 15; n++) begin
      term = -term * t * t / (real'(2 * n) * real'(2 * n + 1));
      acc  = acc + term;
    end
    return acc;
  endfunction

  // Table entry k = round(1024 * asin(k/512 - 1)), found by bisection on
  // sin() so the table can be built at elaboration without an init file.
  function automatic logic signed [ASIN_W-1:0] asin_entry(input int k);
    real x;
    real ax;
    real lo;
    real hi;
    real mid;
    int  r;
    x  = real'(k) / 512.0 - 1.0;
    ax = (x < 0.0) ? -x : x;
    lo = 0.0;
    hi = HALF_PI;
    for (int i = 0; i < 56; i++) begin
      mid = (lo + hi) * 0.5;
      if (sin_series(mid) < ax) lo = mid;
      else                      hi = mid;
    end
    r = $rtoi(lo * 1024.0 + 0.5);
    if (x < 0.0) r = -r;
    return ASIN_W'(r);
  endfunction

endpackage

// File: rtl/servo_pwm_drive_asin_lut.sv
// ---------------------------------------------------------------------------
// asin_lut
// Purpose : 1024 x 13 synchronous arcsine ROM, one cycle read latency.
//           Entry k holds round(1024*asin(k/512 - 1)) in Q2.10.
// Ports   : clock - system clock
//           addr  - table index (offset-binary arcsine argument >> 6)
//           data  - registered table output
// ---------------------------------------------------------------------------
module asin_lut
  import servo_pkg::*;
(
  input  logic              clock,
  input  logic [ADDR_W-1:0] addr,
  output logic [ASIN_W-1:0] data
);

  logic [ASIN_W-1:0] rom [LUT_DEPTH];
  logic [ASIN_W-1:0] data_d;
  logic [ASIN_W-1:0] data_q;

  for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
    localparam logic [ASIN_W-1:0] ENTRY = asin_entry(gi);
    assign rom[gi] = ENTRY;
  end

  always_comb begin
    data_d = rom[addr];
  end

  // Unreset output register keeps the read a plain ROM read port.
  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/servo_pwm_drive.sv
// ---------------------------------------------------------------------------
// servo_pwm_drive
// Purpose : converts one leg's IK terms into a 50 Hz servo PWM.
//           alpha = asin(LUTin) - atan, width = CENTER +/- alpha*gain,
//           saturated; new widths take effect only at frame boundaries.
// Ports   : clock, reset (async active-low)
//           validIn/LUTin/atan - command strobe, Q1.15 arg, Q2.10 atan
//           pwm          - servo drive
//           pulse_us     - width in use for the current frame
//           sat          - last accepted command was clamped
//           frame_start  - first cycle of each frame
//           validOut     - new pending width latched (5 cycles after validIn)
// ---------------------------------------------------------------------------
module servo_pwm_drive
  import servo_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int PERIOD_US  = DEF_PERIOD_US,
  parameter int CENTER_US  = DEF_CENTER_US,
  parameter int MIN_US     = DEF_MIN_US,
  parameter int MAX_US     = DEF_MAX_US,
  parameter int US_PER_RAD = DEF_US_PER_RAD,
  parameter int REVERSE    = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         validIn,
  input  logic [16:0]  LUTin,
  input  logic [12:0]  atan,
  output logic         pwm,
  output logic [11:0]  pulse_us,
  output logic         sat,
  output logic         frame_start,
  output logic         validOut
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int UW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam logic signed [LUTIN_W-1:0] LUT_HI = 17'sd32767;
  localparam logic signed [LUTIN_W-1:0] LUT_LO = -17'sd32768;
  localparam logic signed [16:0] MIN_S = 17'(MIN_US);
  localparam logic signed [16:0] MAX_S = 17'(MAX_US);

  // Pipeline state
  logic s1_valid_d, s1_valid_q, s1_sat_d, s1_sat_q;
  logic [ADDR_W-1:0] s1_addr_d, s1_addr_q;
  logic [12:0] s1_atan_d, s1_atan_q;
  logic s2_valid_d, s2_valid_q, s2_sat_d, s2_sat_q;
  logic [12:0] s2_atan_d, s2_atan_q;
  logic [ASIN_W-1:0] asin_q;
  logic s3_valid_d, s3_valid_q, s3_sat_d, s3_sat_q;
  logic [ALPHA_W-1:0] s3_alpha_d, s3_alpha_q;
  logic s4_valid_d, s4_valid_q, s4_sat_d, s4_sat_q;
  logic [OFF_W-1:0] s4_off_d, s4_off_q;
  logic [11:0] pending_d, pending_q;
  logic pending_valid_d, pending_valid_q;
  logic sat_d, sat_q, valid_out_d, valid_out_q;

  // Frame timer state
  logic [PW-1:0] presc_d, presc_q;
  logic [UW-1:0] us_d, us_q;
  logic [11:0] pulse_us_d, pulse_us_q;
  logic pwm_d, pwm_q, frame_start_d, frame_start_q;

  // Combinational helpers
  logic [PROD_W-1:0] prod;
  logic [OFF_W-1:0] off_raw;
  logic [16:0] w_sum;
  logic [11:0] w_sat;
  logic w_lim, tick, at_frame;
  logic lut_lsb_unused, prod_lsb_unused;

  assign lut_lsb_unused  = ^LUTin[5:0];
  assign prod_lsb_unused = ^prod[9:0];

  asin_lut u_asin_lut (
    .clock (clock),
    .addr  (s1_addr_q),
    .data  (asin_q)
  );

  always_comb begin
    // S1: clamp to Q1.15 and form the offset-binary table index.
    s1_valid_d = validIn;
    s1_atan_d  = atan;
    s1_sat_d   = 1'b0;
    s1_addr_d  = {~LUTin[15], LUTin[14:6]};
    if ($signed(LUTin) > LUT_HI) begin
      s1_addr_d = '1;
      s1_sat_d  = 1'b1;
    end else if ($signed(LUTin) < LUT_LO) begin
      s1_addr_d = '0;
      s1_sat_d  = 1'b1;
    end

    // S2: ROM read happens inside asin_lut; side-band follows it.
    s2_valid_d = s1_valid_q;
    s2_sat_d   = s1_sat_q;
    s2_atan_d  = s1_atan_q;

    // S3: one extra bit holds the full asin - atan range.
    s3_valid_d = s2_valid_q;
    s3_sat_d   = s2_sat_q;
    s3_alpha_d = {asin_q[ASIN_W-1], asin_q} - {s2_atan_q[12], s2_atan_q};

    // S4: low PROD_W bits of the product are the same for signed and
    // unsigned operands once both are extended, so unsigned multiply is used.
    s4_valid_d = s3_valid_q;
    s4_sat_d   = s3_sat_q;
    prod       = {{(PROD_W-ALPHA_W){s3_alpha_q[ALPHA_W-1]}}, s3_alpha_q}
                 * PROD_W'(US_PER_RAD);
    off_raw    = {prod[PROD_W-1], prod[PROD_W-1:10]};
    s4_off_d   = (REVERSE != 0) ? -off_raw : off_raw;

    // S5: centre, saturate, latch as pending.
    w_sum = 17'(CENTER_US) + {s4_off_q[OFF_W-1], s4_off_q};
    w_lim = 1'b0;
    w_sat = w_sum[11:0];
    if ($signed(w_sum) > MAX_S) begin
      w_sat = 12'(MAX_US);
      w_lim = 1'b1;
    end else if ($signed(w_sum) < MIN_S) begin
      w_sat = 12'(MIN_US);
      w_lim = 1'b1;
    end
    valid_out_d = s4_valid_q;
    pending_d   = pending_q;
    sat_d       = sat_q;
    if (s4_valid_q) begin
      pending_d = w_sat;
      sat_d     = s4_sat_q | w_lim;
    end

    // Frame timer. The frame begins on the cycle where both counters are 0;
    // pending is sampled from the register, so a command landing on that
    // same edge waits a full frame.
    tick     = (presc_q == PW'(CLK_DIV - 1));
    at_frame = (presc_q == '0) && (us_q == '0);
    presc_d  = tick ? '0 : presc_q + PW'(1);
    us_d     = us_q;
    if (tick) us_d = (us_q == UW'(PERIOD_US - 1)) ? '0 : us_q + UW'(1);

    pulse_us_d = pulse_us_q;
    if (at_frame && pending_valid_q) pulse_us_d = pending_q;

    pending_valid_d = pending_valid_q;
    if (s4_valid_q)    pending_valid_d = 1'b1;
    else if (at_frame) pending_valid_d = 1'b0;

    frame_start_d = at_frame;
    pwm_d         = (32'(us_q) < 32'(pulse_us_d));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0; s1_sat_q <= 1'b0; s1_addr_q <= '0; s1_atan_q <= '0;
      s2_valid_q <= 1'b0; s2_sat_q <= 1'b0; s2_atan_q <= '0;
      s3_valid_q <= 1'b0; s3_sat_q <= 1'b0; s3_alpha_q <= '0;
      s4_valid_q <= 1'b0; s4_sat_q <= 1'b0; s4_off_q <= '0;
      pending_q       <= 12'(CENTER_US);
      pending_valid_q <= 1'b0;
      sat_q           <= 1'b0;
      valid_out_q     <= 1'b0;
      presc_q         <= '0;
      us_q            <= '0;
      pulse_us_q      <= 12'(CENTER_US);
      pwm_q           <= 1'b0;
      frame_start_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d; s1_sat_q <= s1_sat_d;
      s1_addr_q  <= s1_addr_d;  s1_atan_q <= s1_atan_d;
      s2_valid_q <= s2_valid_d; s2_sat_q <= s2_sat_d; s2_atan_q <= s2_atan_d;
      s3_valid_q <= s3_valid_d; s3_sat_q <= s3_sat_d; s3_alpha_q <= s3_alpha_d;
      s4_valid_q <= s4_valid_d; s4_sat_q <= s4_sat_d; s4_off_q <= s4_off_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      sat_q           <= sat_d;
      valid_out_q     <= valid_out_d;
      presc_q         <= presc_d;
      us_q            <= us_d;
      pulse_us_q      <= pulse_us_d;
      pwm_q           <= pwm_d;
      frame_start_q   <= frame_start_d;
    end
  end

  assign pwm         = pwm_q;
  assign pulse_us    = pulse_us_q;
  assign sat         = sat_q;
  assign frame_start = frame_start_q;
  assign validOut    = valid_out_q;

endmodule

// File: tb/tb_servo_pwm_drive.sv
// ---------------------------------------------------------------------------
// tb_servo_pwm_drive
// Drives a normal and a mirrored servo_pwm_drive with shortened frame timing.
// Expected widths are pushed to a scoreboard when a command is driven and
// popped when validOut fires; a frame model tracks pending/pulse_us.
// ---------------------------------------------------------------------------
module tb_servo_pwm_drive;

  localparam int CLK_DIV   = 2;
  localparam int PERIOD_US = 2050;
  localparam int FRAME_CYC = CLK_DIV * PERIOD_US;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        validIn = 1'b0;
  logic [16:0] LUTin = '0;
  logic [12:0] atan = '0;
  logic [1:0]  pwm, sat, frame_start, validOut;
  logic [11:0] pulse_us [2];

  always #5 clock = ~clock;

  servo_pwm_drive #(.CLK_DIV(CLK_DIV), .PERIOD_US(PERIOD_US), .REVERSE(0)) u_dut (
    .clock(clock), .reset(reset), .validIn(validIn), .LUTin(LUTin), .atan(atan),
    .pwm(pwm[0]), .pulse_us(pulse_us[0]), .sat(sat[0]),
    .frame_start(frame_start[0]), .validOut(validOut[0])
  );

  servo_pwm_drive #(.CLK_DIV(CLK_DIV), .PERIOD_US(PERIOD_US), .REVERSE(1)) u_dut_rev (
    .clock(clock), .reset(reset), .validIn(validIn), .LUTin(LUTin), .atan(atan),
    .pwm(pwm[1]), .pulse_us(pulse_us[1]), .sat(sat[1]),
    .frame_start(frame_start[1]), .validOut(validOut[1])
  );

  typedef struct {
    int w0;
    int w1;
    int s;
    int cyc;
  } exp_t;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  int   model_pulse [2];
  int   model_pend  [2];
  int   hi_cnt      [2];
  bit   model_pv;
  bit   frame_ok;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic send(input logic [16:0] lut, input logic [12:0] at,
                      input int w0, input int w1, input int s);
    exp_t e;
    LUTin   = lut;
    atan    = at;
    validIn = 1'b1;
    e.w0 = w0; e.w1 = w1; e.s = s; e.cyc = cyc;
    sb.push_back(e);
    $display("cmd    cyc=%0d LUTin=%0d atan=%0d expect w=%0d rev=%0d sat=%0d",
             cyc, $signed(lut), $signed(at), w0, w1, s);
    @(negedge clock);
    validIn = 1'b0;
  endtask

  task automatic wait_fs();
    bit got;
    got = 1'b0;
    for (int i = 0; i < FRAME_CYC + 10 && !got; i++) begin
      @(negedge clock);
      if (frame_start[0]) got = 1'b1;
    end
    check_val("frame_wait", int'(got), 1);
  endtask

  // Frame and scoreboard monitor. Frame boundary is handled before validOut:
  // a width latched on the frame's first edge must not be loaded by it.
  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        model_pulse[i] = 1500;
        model_pend[i]  = 1500;
        hi_cnt[i]      = 0;
      end
      model_pv = 1'b0;
      frame_ok = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (frame_start[i]) begin
          if (frame_ok) check_val(i == 0 ? "pwm_width" : "pwm_width_rev",
                                  hi_cnt[i], model_pulse[i] * CLK_DIV);
          if (model_pv) model_pulse[i] = model_pend[i];
          check_val(i == 0 ? "pulse_frame" : "pulse_frame_rev",
                    int'(pulse_us[i]), model_pulse[i]);
          hi_cnt[i] = 0;
        end
        if (pwm[i]) hi_cnt[i]++;
      end
      if (frame_start[0]) begin
        model_pv = 1'b0;
        frame_ok = 1'b1;
      end
      if (validOut[0]) begin
        check_val("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          $display("result cyc=%0d pulse_us=%0d/%0d sat=%0d/%0d", cyc,
                   pulse_us[0], pulse_us[1], sat[0], sat[1]);
          check_val("latency", cyc - e.cyc, 5);
          check_val("valid_rev", int'(validOut[1]), 1);
          check_val("sat", int'(sat[0]), e.s);
          check_val("sat_rev", int'(sat[1]), e.s);
          check_val("pulse_not_yet", int'(pulse_us[0]), model_pulse[0]);
          model_pend[0] = e.w0;
          model_pend[1] = e.w1;
          model_pv      = 1'b1;
        end
      end
    end
  end

  initial begin
    int hi;
    int first_lo;
    int fs_cyc;

    // Reset state
    repeat (3) @(negedge clock);
    check_val("rst_pwm", int'(pwm[0]), 0);
    check_val("rst_pulse", int'(pulse_us[0]), 1500);
    check_val("rst_pulse_rev", int'(pulse_us[1]), 1500);
    check_val("rst_sat", int'(sat[0]), 0);
    check_val("rst_fs", int'(frame_start[0]), 0);
    check_val("rst_vo", int'(validOut[0]), 0);
    reset = 1'b1;

    // Reset in the middle of a pulse, then one clean frame
    wait_fs();
    repeat (700 * CLK_DIV) @(negedge clock);
    check_val("pre_rst_pwm", int'(pwm[0]), 1);
    reset = 1'b0;
    #1;
    check_val("rst_async_pwm", int'(pwm[0]), 0);
    check_val("rst_async_pwm_rev", int'(pwm[1]), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_val("rel_fs", int'(frame_start[0]), 1);
    hi = 0;
    first_lo = -1;
    for (int i = 0; i < FRAME_CYC; i++) begin
      if (pwm[0]) hi++;
      else if (first_lo < 0) first_lo = i;
      @(negedge clock);
    end
    check_val("rel_hi", hi, 1500 * CLK_DIV);
    check_val("rel_first_lo", first_lo, 1500 * CLK_DIV);
    check_val("rel_fs2", int'(frame_start[0]), 1);

    // Zero angle
    repeat (50) @(negedge clock);
    send(17'h00000, 13'h0000, 1500, 1500, 0);
    wait_fs();
    // Nominal
    repeat (50) @(negedge clock);
    send(17'h04000, 13'h0000, 1833, 1167, 0);
    wait_fs();
    // Pulse-limit saturation
    repeat (50) @(negedge clock);
    send(17'h07FFF, 13'h1C00, 2000, 1000, 1);
    wait_fs();
    // LUTin below range
    repeat (50) @(negedge clock);
    send(17'h10000, 13'h0000, 1000, 2000, 1);
    wait_fs();
    // Last command in a frame wins
    repeat (50) @(negedge clock);
    send(17'h00000, 13'd481, 1200, 1800, 0);
    repeat (10) @(negedge clock);
    send(17'h00000, 13'h1E1D, 1800, 1200, 0);
    wait_fs();
    // Back-to-back: LUTin above range, then an unsaturated negative angle
    repeat (50) @(negedge clock);
    send(17'h09C40, 13'h0400, 1823, 1177, 1);
    send(17'h1C000, 13'd100, 1104, 1896, 0);
    wait_fs();
    // validOut coinciding with frame_start waits one more frame
    fs_cyc = cyc;
    repeat (FRAME_CYC - 5) @(negedge clock);
    check_val("coincide_setup", cyc - fs_cyc, FRAME_CYC - 5);
    send(17'h00000, 13'd481, 1200, 1800, 0);
    wait_fs();
    check_val("coincide_vo", int'(validOut[0]), 1);
    check_val("coincide_hold", int'(pulse_us[0]), 1104);
    wait_fs();
    // No command: width holds
    wait_fs();
    check_val("hold_pulse", int'(pulse_us[0]), 1200);
    check_val("hold_pulse_rev", int'(pulse_us[1]), 1800);
    repeat (5) @(negedge clock);
    check_val("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
